// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: FSM state encoding and field widths.
package loader_defs;

    localparam int NIB_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_HOLD = 2'd2,
        S_BAD  = 2'd3
    } state_t;

endpackage

// File: rtl/operand_loader_nibble_shift_reg.sv
// Hex-digit shift-in register with a saturating digit counter.
// Once the register is full, further digits are dropped so the value cannot scroll.
module nibble_shift_reg
    import loader_defs::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = WIDTH / NIB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [NIB_W-1:0] nib,
    output logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value <= '0;
            count <= '0;
        end else if (load && (count < DIGITS_C)) begin
            value <= {value[WIDTH-NIB_W-1:0], nib};
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Operand entry front-end: sequences A entry, B entry and a HOLD phase in which the
// downstream element's result is captured while both operands stay frozen.
module operand_loader
    import loader_defs::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       nib_in,
    input  logic             nib_stb,
    input  logic             enter,
    input  logic             clr,
    input  logic [WIDTH-1:0] res_in,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             ab_valid,
    output logic             done,
    output logic [1:0]       state,
    output logic [3:0]       digit_cnt,
    output logic [WIDTH-1:0] res_q
);

    state_t           state_q;
    logic             in_a, in_b, in_hold, in_bad;
    logic             a_clear, b_clear, a_load, b_load;
    logic [CNT_W-1:0] a_cnt, b_cnt;

    assign in_a    = (state_q == S_A);
    assign in_b    = (state_q == S_B);
    assign in_hold = (state_q == S_HOLD);
    assign in_bad  = (state_q == S_BAD);

    // clr outranks enter, which outranks a digit strobe in the same cycle.
    assign a_clear = clr | (in_hold & enter) | in_bad;
    assign b_clear = clr | ((in_a | in_hold) & enter) | in_bad;
    assign a_load  = in_a & nib_stb & ~enter & ~clr;
    assign b_load  = in_b & nib_stb & ~enter & ~clr;

    nibble_shift_reg #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_reg_a (
        .clk   (clk),
        .rst   (rst),
        .clear (a_clear),
        .load  (a_load),
        .nib   (nib_in),
        .value (A),
        .count (a_cnt)
    );

    nibble_shift_reg #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_reg_b (
        .clk   (clk),
        .rst   (rst),
        .clear (b_clear),
        .load  (b_load),
        .nib   (nib_in),
        .value (B),
        .count (b_cnt)
    );

    // res_q samples on every HOLD cycle, including the one in which HOLD is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_A;
            ab_valid <= 1'b0;
            done     <= 1'b0;
            res_q    <= '0;
        end else begin
            done <= 1'b0;
            if (in_hold) begin
                res_q <= res_in;
            end
            unique case (state_q)
                S_A: begin
                    if (!clr && enter) begin
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (clr) begin
                        state_q <= S_A;
                    end else if (enter) begin
                        state_q  <= S_HOLD;
                        ab_valid <= 1'b1;
                        done     <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (clr || enter) begin
                        state_q  <= S_A;
                        ab_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_A;
                    ab_valid <= 1'b0;
                    res_q    <= '0;
                end
            endcase
        end
    end

    always_comb begin
        digit_cnt = '0;
        unique case (state_q)
            S_A:     digit_cnt = a_cnt;
            S_B:     digit_cnt = b_cnt;
            default: digit_cnt = '0;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader with an or32-style element on res_in.
// A behavioural model pushes the expected outputs per cycle; they are popped after the edge.
module tb_operand_loader;

    logic        clk = 1'b0;
    logic        rst, nib_stb, enter, clr;
    logic [3:0]  nib_in;
    logic [31:0] res_in;
    logic [31:0] a, b, res_q;
    logic        ab_valid, done;
    logic [1:0]  state;
    logic [3:0]  digit_cnt;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [1:0]  st;
        logic [3:0]  cnt;
        logic        v;
        logic        d;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    assign res_in = a | b;

    operand_loader #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .nib_in    (nib_in),
        .nib_stb   (nib_stb),
        .enter     (enter),
        .clr       (clr),
        .res_in    (res_in),
        .A         (a),
        .B         (b),
        .ab_valid  (ab_valid),
        .done      (done),
        .state     (state),
        .digit_cnt (digit_cnt),
        .res_q     (res_q)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs after the edge, then compare.
    task automatic applyStimulus(input logic r, input logic c, input logic e,
                                 input logic s, input logic [3:0] n);
        exp_t nx;
        exp_t want;
        rst = r; clr = c; enter = e; nib_stb = s; nib_in = n;
        nx   = m;
        nx.d = 1'b0;
        if (r) begin
            nx = '0;
        end else begin
            if (m.st == 2'd2) nx.res = m.a | m.b;
            if (c) begin
                nx.st = 2'd0; nx.a = '0; nx.b = '0; nx.cnt = '0;
            end else if (e) begin
                if (m.st == 2'd0) begin
                    nx.st = 2'd1; nx.cnt = '0; nx.b = '0;
                end else if (m.st == 2'd1) begin
                    nx.st = 2'd2; nx.cnt = '0; nx.d = 1'b1;
                end else begin
                    nx.st = 2'd0; nx.a = '0; nx.b = '0; nx.cnt = '0;
                end
            end else if (s && m.st != 2'd2 && m.cnt < 4'd8) begin
                if (m.st == 2'd0) nx.a = {m.a[27:0], n};
                else              nx.b = {m.b[27:0], n};
                nx.cnt = m.cnt + 4'd1;
            end
            nx.v = (nx.st == 2'd2);
        end
        m = nx;
        sb.push_back(nx);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        checkOutput("A",         a,                 want.a);
        checkOutput("B",         b,                 want.b);
        checkOutput("res_q",     res_q,             want.res);
        checkOutput("state",     {30'd0, state},    {30'd0, want.st});
        checkOutput("digit_cnt", {28'd0, digit_cnt}, {28'd0, want.cnt});
        checkOutput("ab_valid",  {31'd0, ab_valid}, {31'd0, want.v});
        checkOutput("done",      {31'd0, done},     {31'd0, want.d});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic digit(input logic [3:0] n);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, n);
    endtask

    task automatic pressEnter();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    endtask

    task automatic pressClr();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        m = '0;
        rst = 1'b1; clr = 1'b0; enter = 1'b0; nib_stb = 1'b0; nib_in = 4'h0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        idle(5);
        checkOutput("reset_state", {30'd0, state}, 32'd0);

        // All-ones A, all-zeros B, then watch the OR result land in res_q.
        for (int i = 0; i < 8; i++) digit(4'hF);
        pressEnter();
        checkOutput("a_ones", a, 32'hFFFF_FFFF);
        checkOutput("state_b", {30'd0, state}, 32'd1);
        for (int i = 0; i < 8; i++) digit(4'h0);
        pressEnter();
        checkOutput("hold_done", {31'd0, done}, 32'd1);
        idle(1);
        checkOutput("res_or", res_q, 32'hFFFF_FFFF);
        checkOutput("done_low", {31'd0, done}, 32'd0);
        digit(4'h7);
        idle(2);
        pressEnter();

        // Nine digits: the ninth is dropped at saturation.
        for (int i = 1; i <= 9; i++) digit(4'(i));
        checkOutput("a_sat", a, 32'h1234_5678);
        checkOutput("cnt_sat", {28'd0, digit_cnt}, 32'd8);
        pressClr();

        // Strobe coinciding with enter is discarded.
        digit(4'hA);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
        checkOutput("a_keep", a, 32'h0000_000A);
        pressClr();

        // Capture res_q = 5, then clr during B entry must keep it.
        digit(4'h1);
        pressEnter();
        digit(4'h4);
        pressEnter();
        idle(2);
        pressEnter();
        pressEnter();
        digit(4'hA); digit(4'hB); digit(4'hC);
        checkOutput("b_abc", b, 32'h0000_0ABC);
        pressClr();
        checkOutput("res_kept", res_q, 32'h0000_0005);

        // Reset in the middle of HOLD.
        digit(4'h3);
        pressEnter();
        digit(4'h0); digit(4'hC);
        pressEnter();
        idle(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("rst_res", res_q, 32'd0);
        idle(2);

        // Back-to-back random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
# operand_loader

Sequential front-end that feeds the 32-bit logic/arithmetic elements (`or32`, `and32` and their siblings) with their `A`/`B` operands. The user enters operands one hex digit at a time. A small FSM sequences A entry, then B entry, then a hold phase. In the hold phase both operands are presented stable, and the element's combinational `res` is captured into a result register. It sits between the board input logic (debounced switches/keys) and the element under exercise.

## Interface
Parameters:
- `WIDTH`, 32, operand width; must be a multiple of 4.
- `DIGITS`, `WIDTH/4`, derived; hex digits per operand.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `nib_in` in 4: hex digit to append.
- `nib_stb` in 1: one-cycle strobe; `nib_in` is valid in this cycle.
- `enter` in 1: one-cycle strobe; commit the current phase.
- `clr` in 1: one-cycle strobe; abort and restart at A entry.
- `res_in` in `WIDTH`: combinational result from the downstream element.
- `A` out `WIDTH`: operand A register.
- `B` out `WIDTH`: operand B register.
- `ab_valid` out 1: high while in HOLD.
- `done` out 1: one-cycle pulse on the first HOLD cycle.
- `state` out 2: current FSM state.
- `digit_cnt` out 4: digits entered in the current phase (0..`DIGITS`).
- `res_q` out `WIDTH`: captured result.

## Operation
- States:
  - `S_A` (2'd0): A entry.
  - `S_B` (2'd1): B entry.
  - `S_HOLD` (2'd2): operands frozen.
  - 2'd3 is unused; if reached, the next cycle goes to `S_A` with all registers cleared.
- Input priority within a cycle: `rst` > `clr` > `enter` > `nib_stb`.
  - A `nib_stb` coinciding with `enter` or `clr` is discarded.
- `S_A`, `nib_stb`:
  - If `digit_cnt < DIGITS`: `A <= {A[WIDTH-5:0], nib_in}` and `digit_cnt++`.
  - At `DIGITS`: the strobe is ignored and `A` and `digit_cnt` are unchanged.
- `S_A`, `enter`: go to `S_B`, `digit_cnt <= 0`, `B <= 0`, `A` retained. Entering zero digits is legal and gives A = 0.
- `S_B`: same digit rules applied to `B`.
- `S_B`, `enter`: go to `S_HOLD`, `digit_cnt <= 0`.
- `S_HOLD`:
  - `nib_stb` is ignored.
  - `res_q <= res_in` every cycle.
  - `enter` goes to `S_A` with `A`, `B`, `digit_cnt` cleared; `res_q` keeps its last captured value.
- `clr` in any state: go to `S_A`; clear `A`, `B`, `digit_cnt`; `res_q` is retained.
- `rst`: all outputs 0 and state `S_A`, including `res_q`.

## Timing
- Reset values: `A`, `B`, `res_q` = 0; `state` = 0; `digit_cnt` = 0; `ab_valid` = 0; `done` = 0.
- Digit latency: a strobe in cycle n is visible on `A`/`B` and `digit_cnt` in cycle n+1.
- `enter` in `S_B` at cycle n:
  - `state` = `S_HOLD`, `ab_valid` = 1 and `done` = 1 in cycle n+1.
  - `done` = 0 from cycle n+2.
  - `res_q` first holds `res_in` (for the held operands) in cycle n+2.
- `ab_valid` is a registered decode of `state == S_HOLD`; `done` is registered.
- Leaving HOLD (`enter` or `clr` at cycle m): `ab_valid` = 0 in cycle m+1; `res_q` holds the value sampled at edge m+1.
- `A`/`B` never change while `ab_valid` = 1; the downstream element sees stable operands throughout HOLD.
- Back-to-back strobes every cycle are supported; there is no minimum spacing.

## Structure
- Shared package/header `loader_defs`:
  - State constants `S_A`, `S_B`, `S_HOLD`.
  - Nibble width 4.
  - Counter width 4.
- Sub-module `nibble_shift_reg` (param `WIDTH`):
  - Shift-in register with saturating digit counter, synchronous clear and load enable.
  - Instantiated twice, for A and B.
  - The top level holds the FSM, `res_q` and output decode.

## Test plan
- Reset then idle 5 cycles -> all outputs 0, `state` = 0.
- A entry: digits F,F,F,F,F,F,F,F, `enter` -> A = 32'hFFFFFFFF, `state` = 1. B entry: digits 0 ×8, `enter` -> B = 32'h00000000; `ab_valid` = 1 and a one-cycle `done`; with `or32` attached, `res_q` = 32'hFFFFFFFF one cycle later.
- A entry: 9 digits 1..9 -> A = 32'h12345678, `digit_cnt` = 8; the 9th digit is ignored.
- `nib_stb` and `enter` in the same cycle in `S_A` with A = 32'h0000000A -> A unchanged, `state` = 1, B = 0.
- `clr` in `S_B` after B = 32'h00000ABC, with `res_q` = 32'h00000005 -> next cycle `state` = 0, A = B = 0, `res_q` still 32'h00000005.
- `rst` asserted mid-HOLD (`res_q` nonzero) -> next cycle everything 0, `ab_valid` = 0, no `done` pulse.
